// File: rtl/pad_mux_seq.sv
// pad_mux_seq
//   Shares the bidirectional GPIO pads between the GPIO controller and the
//   alternate-function peripherals. When the requested owner of one or more
//   pads changes, those pads are isolated (driver released, receiver gated)
//   for SETTLE_CYCLES cycles plus one swap cycle. Ownership is then swapped
//   and the pads are re-enabled under the new owner. Pads that do not change
//   owner are never disturbed.
//
// Optional build macro:
//   PAD_SYNC_EN - adds a 2-flop synchroniser on every pad_c_i bit before
//                 capture. Input latency becomes 3 cycles, and capture gating
//                 uses the iso mask delayed to line up with the synchronised
//                 sample.
//
// Ports:
//   clk, rst      core clock, synchronous active-high reset
//   mux_req_i     requested owner per pad (1 = alternate, 0 = GPIO)
//   gpio_out_i    GPIO drive value
//   gpio_dir_i    GPIO direction (1 = output)
//   gpio_pe_i     GPIO pull enable
//   gpio_in_o     pad value returned to GPIO
//   alt_out_i     alternate-function drive value
//   alt_oe_i      alternate-function output enable (1 = drive)
//   alt_in_o      pad value returned to the alternate function
//   pad_c_i       pad receiver output (C)
//   pad_i_o       pad driver input (I)
//   pad_oen_o     pad output enable, active-low
//   pad_ie_o      pad input enable
//   pad_pe_o      pad pull enable
//   mux_cur_o     committed owner per pad
//   busy_o        a switch sequence is in progress
module pad_mux_seq #(
    parameter int                     NUM_PADS      = 9,
    parameter int                     SETTLE_CYCLES = 4,
    parameter logic [NUM_PADS-1:0]    ALT_IDLE      = {NUM_PADS{1'b1}}
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_PADS-1:0] mux_req_i,
    input  logic [NUM_PADS-1:0] gpio_out_i,
    input  logic [NUM_PADS-1:0] gpio_dir_i,
    input  logic [NUM_PADS-1:0] gpio_pe_i,
    output logic [NUM_PADS-1:0] gpio_in_o,
    input  logic [NUM_PADS-1:0] alt_out_i,
    input  logic [NUM_PADS-1:0] alt_oe_i,
    output logic [NUM_PADS-1:0] alt_in_o,
    input  logic [NUM_PADS-1:0] pad_c_i,
    output logic [NUM_PADS-1:0] pad_i_o,
    output logic [NUM_PADS-1:0] pad_oen_o,
    output logic [NUM_PADS-1:0] pad_ie_o,
    output logic [NUM_PADS-1:0] pad_pe_o,
    output logic [NUM_PADS-1:0] mux_cur_o,
    output logic                busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

    state_t              state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [NUM_PADS-1:0] iso_q, iso_d;
    logic [NUM_PADS-1:0] cur_q, cur_d;

    logic [NUM_PADS-1:0] pad_i_q, pad_i_d;
    logic [NUM_PADS-1:0] pad_oen_q, pad_oen_d;
    logic [NUM_PADS-1:0] pad_ie_q, pad_ie_d;
    logic [NUM_PADS-1:0] pad_pe_q, pad_pe_d;
    logic [NUM_PADS-1:0] gpio_in_q, gpio_in_d;
    logic [NUM_PADS-1:0] alt_in_q, alt_in_d;

    logic [NUM_PADS-1:0] drive_en;
    logic [NUM_PADS-1:0] c_cap;
    logic [NUM_PADS-1:0] iso_gate;

`ifdef PAD_SYNC_EN
    logic [NUM_PADS-1:0] sync1_q, sync1_d;
    logic [NUM_PADS-1:0] sync2_q, sync2_d;
    logic [NUM_PADS-1:0] iso_dly1_q, iso_dly1_d;
    logic [NUM_PADS-1:0] iso_dly2_q, iso_dly2_d;

    // The synchronised sample is two cycles old, so gate it with the
    // isolation mask from the cycle in which it was taken.
    always_comb begin
        sync1_d    = pad_c_i;
        sync2_d    = sync1_q;
        iso_dly1_d = iso_q;
        iso_dly2_d = iso_dly1_q;
        c_cap      = sync2_q;
        iso_gate   = iso_dly2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            iso_dly1_q <= '0;
            iso_dly2_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            iso_dly1_q <= iso_dly1_d;
            iso_dly2_q <= iso_dly2_d;
        end
    end
`else
    always_comb begin
        c_cap    = pad_c_i;
        iso_gate = iso_q;
    end
`endif

    // State register and all registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            iso_q     <= '0;
            cur_q     <= '0;
            pad_i_q   <= '0;
            pad_oen_q <= '1;
            pad_ie_q  <= '0;
            pad_pe_q  <= '0;
            gpio_in_q <= '0;
            alt_in_q  <= ALT_IDLE;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            iso_q     <= iso_d;
            cur_q     <= cur_d;
            pad_i_q   <= pad_i_d;
            pad_oen_q <= pad_oen_d;
            pad_ie_q  <= pad_ie_d;
            pad_pe_q  <= pad_pe_d;
            gpio_in_q <= gpio_in_d;
            alt_in_q  <= alt_in_d;
        end
    end

    // Next-state logic. Requests are only sampled in IDLE, so changes made
    // while a sequence runs are picked up on the first IDLE cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        iso_d   = iso_q;
        cur_d   = cur_q;
        case (state_q)
            ST_IDLE: begin
                if (|(mux_req_i ^ cur_q)) begin
                    iso_d   = mux_req_i ^ cur_q;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (cnt_q == 8'd0) begin
                    state_d = ST_SWITCH;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_SWITCH: begin
                cur_d   = cur_q ^ iso_q;
                iso_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                iso_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output logic. Pad controls are computed from the next iso mask and
    // owner so isolation takes effect on the very edge a request is accepted
    // and the new owner drives on the edge that leaves SWITCH.
    always_comb begin
        busy_o    = (state_q != ST_IDLE);
        drive_en  = (cur_d & alt_oe_i) | (~cur_d & gpio_dir_i);
        pad_i_d   = ~iso_d & ((cur_d & alt_out_i) | (~cur_d & gpio_out_i));
        pad_oen_d = iso_d | ~drive_en;
        pad_ie_d  = ~iso_d & ~drive_en;
        pad_pe_d  = ~iso_d & ~cur_d & gpio_pe_i;

        // GPIO return holds unless the pad is GPIO-owned and not isolated.
        gpio_in_d = (~cur_q & ~iso_gate & c_cap)
                  | ((cur_q | iso_gate) & gpio_in_q);

        // Alternate return is forced to ALT_IDLE whenever the pad is not
        // alt-owned (aligned with mux_cur_o), else samples or holds.
        alt_in_d  = (~cur_d & ALT_IDLE)
                  | (cur_d & cur_q & ~iso_gate & c_cap)
                  | (cur_d & ~(cur_q & ~iso_gate) & alt_in_q);
    end

    assign pad_i_o   = pad_i_q;
    assign pad_oen_o = pad_oen_q;
    assign pad_ie_o  = pad_ie_q;
    assign pad_pe_o  = pad_pe_q;
    assign gpio_in_o = gpio_in_q;
    assign alt_in_o  = alt_in_q;
    assign mux_cur_o = cur_q;

endmodule

// File: tb/tb_pad_mux_seq.sv
module tb_pad_mux_seq;

    localparam int         N        = 9;
    localparam int         S        = 4;
    localparam logic [8:0] ALT_IDLE = 9'h1FF;

    logic       clk = 1'b0;
    logic       rst;
    logic [8:0] mux_req, gpio_out, gpio_dir, gpio_pe, alt_out, alt_oe, pad_c;
    logic [8:0] gpio_in, alt_in, pad_i, pad_oen, pad_ie, pad_pe, mux_cur;
    logic       busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pad_mux_seq #(.NUM_PADS(N), .SETTLE_CYCLES(S), .ALT_IDLE(ALT_IDLE)) dut (
        .clk(clk), .rst(rst),
        .mux_req_i(mux_req), .gpio_out_i(gpio_out), .gpio_dir_i(gpio_dir),
        .gpio_pe_i(gpio_pe), .gpio_in_o(gpio_in), .alt_out_i(alt_out),
        .alt_oe_i(alt_oe), .alt_in_o(alt_in), .pad_c_i(pad_c),
        .pad_i_o(pad_i), .pad_oen_o(pad_oen), .pad_ie_o(pad_ie),
        .pad_pe_o(pad_pe), .mux_cur_o(mux_cur), .busy_o(busy)
    );

    // Reference model: a sequence accepted at cycle t0 keeps its pads
    // isolated and busy high for cycles t0+1 .. t0+S+1; ownership flips
    // from cycle t0+S+2 on.
    int         cyc = 0;
    int         m_t0 = 0;
    logic       m_busy = 1'b0;
    logic [8:0] m_cur = '0, m_iso = '0, m_mask = '0;
    logic [8:0] e_pad_i, e_oen, e_ie, e_pe, e_gin, e_ain;
    logic       n_busy;
    logic [8:0] n_cur, n_iso;

    always @(posedge clk) begin
        if (rst) begin
            m_cur = '0; m_iso = '0; m_busy = 1'b0;
            e_pad_i = '0; e_oen = '1; e_ie = '0; e_pe = '0;
            e_gin = '0; e_ain = ALT_IDLE;
        end else begin
            n_cur = m_cur; n_iso = '0; n_busy = 1'b0;
            if (!m_busy) begin
                if ((mux_req ^ m_cur) != 9'd0) begin
                    m_t0 = cyc; m_mask = mux_req ^ m_cur;
                    n_busy = 1'b1; n_iso = m_mask;
                end
            end else if (cyc == m_t0 + S + 1) begin
                n_cur = m_cur ^ m_mask;
            end else begin
                n_busy = 1'b1; n_iso = m_mask;
            end
            for (int k = 0; k < N; k++) begin
                if (!m_cur[k] && !m_iso[k]) e_gin[k] = pad_c[k];
                if (!n_cur[k]) e_ain[k] = ALT_IDLE[k];
                else if (m_cur[k] && !m_iso[k]) e_ain[k] = pad_c[k];
                if (n_iso[k]) begin
                    e_pad_i[k] = 1'b0; e_oen[k] = 1'b1; e_ie[k] = 1'b0; e_pe[k] = 1'b0;
                end else if (n_cur[k]) begin
                    e_pad_i[k] = alt_out[k]; e_oen[k] = !alt_oe[k];
                    e_ie[k] = !alt_oe[k]; e_pe[k] = 1'b0;
                end else begin
                    e_pad_i[k] = gpio_out[k]; e_oen[k] = !gpio_dir[k];
                    e_ie[k] = !gpio_dir[k]; e_pe[k] = gpio_pe[k];
                end
            end
            m_cur = n_cur; m_iso = n_iso; m_busy = n_busy;
        end
        cyc++;
    end

    task automatic chk(input string tag, input logic [8:0] got, input logic [8:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic check_model();
        chk("m_pad_i", pad_i, e_pad_i);
        chk("m_oen", pad_oen, e_oen);
        chk("m_ie", pad_ie, e_ie);
        chk("m_pe", pad_pe, e_pe);
        chk("m_gin", gpio_in, e_gin);
        chk("m_ain", alt_in, e_ain);
        chk("m_cur", mux_cur, m_cur);
        chk("m_busy", {8'd0, busy}, {8'd0, m_busy});
    endtask

    task automatic step();
        @(negedge clk);
        check_model();
    endtask

    initial begin
        bit done;
        rst = 1'b1;
        mux_req = '0; gpio_out = '0; gpio_dir = '0; gpio_pe = '0;
        alt_out = '0; alt_oe = '0; pad_c = '0;

        // 1. reset
        step(); step();
        chk("rst_oen", pad_oen, 9'h1FF);
        chk("rst_ie", pad_ie, 9'h000);
        chk("rst_pe", pad_pe, 9'h000);
        chk("rst_cur", mux_cur, 9'h000);
        chk("rst_busy", {8'd0, busy}, 9'd0);
        chk("rst_gin", gpio_in, 9'h000);
        chk("rst_ain", alt_in, 9'h1FF);
        rst = 1'b0;

        // 2. GPIO drive
        gpio_dir = 9'h001; gpio_out = 9'h001; gpio_pe = 9'h100;
        step();
        chk("gp_i0", {8'd0, pad_i[0]}, 9'd1);
        chk("gp_oen", pad_oen, 9'h1FE);
        chk("gp_ie", pad_ie, 9'h1FE);
        chk("gp_pe", pad_pe, 9'h100);

        // 3 + 4. switch pad 3, then pad 4 requested during the DRAIN
        alt_oe = 9'h008; alt_out = 9'h008;
        mux_req = 9'h008;
        for (int i = 1; i <= 13; i++) begin
            step();
            if (i <= 5) begin
                chk("sw_busy", {8'd0, busy}, 9'd1);
                chk("sw_oen3", {8'd0, pad_oen[3]}, 9'd1);
                chk("sw_ie3", {8'd0, pad_ie[3]}, 9'd0);
                chk("sw_ie4", {8'd0, pad_ie[4]}, 9'd1);
                chk("sw_oth", pad_oen & 9'h1F7, 9'h1F6);
            end else if (i == 6) begin
                chk("sw_cur", mux_cur, 9'h008);
                chk("sw_idle", {8'd0, busy}, 9'd0);
                chk("sw_oen3n", {8'd0, pad_oen[3]}, 9'd0);
                chk("sw_ie4i", {8'd0, pad_ie[4]}, 9'd1);
            end else if (i <= 11) begin
                chk("sw2_busy", {8'd0, busy}, 9'd1);
                chk("sw2_ie4", {8'd0, pad_ie[4]}, 9'd0);
                chk("sw2_oen3", {8'd0, pad_oen[3]}, 9'd0);
                chk("sw2_cur", mux_cur, 9'h008);
            end else begin
                chk("sw2_done", mux_cur, 9'h018);
                chk("sw2_idle", {8'd0, busy}, 9'd0);
            end
            if (i == 2) mux_req = 9'h018;
        end

        // 5. input hold/force on pad 5
        pad_c = 9'h020;
        step(); step();
        chk("in_gin5", {8'd0, gpio_in[5]}, 9'd1);
        chk("in_ain5", {8'd0, alt_in[5]}, 9'd1);
        mux_req = 9'h038;
        for (int i = 1; i <= 6; i++) begin
            step();
            chk("iso_gin5", {8'd0, gpio_in[5]}, 9'd1);
            chk("iso_ain5", {8'd0, alt_in[5]}, 9'd1);
            pad_c[5] = (i < 5) ? ~pad_c[5] : 1'b0;
        end
        step();
        chk("trk_ain5_0", {8'd0, alt_in[5]}, 9'd0);
        chk("trk_gin5", {8'd0, gpio_in[5]}, 9'd1);
        pad_c[5] = 1'b1;
        step();
        chk("trk_ain5_1", {8'd0, alt_in[5]}, 9'd1);
        chk("trk_gin5b", {8'd0, gpio_in[5]}, 9'd1);

        // 6. reset in the middle of a DRAIN
        mux_req = 9'h03C;
        done = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            step();
            if (mux_cur === 9'h03C && busy === 1'b0) done = 1'b1;
        end
        chk("pre_rst_cur", mux_cur, 9'h03C);
        mux_req = 9'h0BC;
        step(); step();
        chk("drain7_busy", {8'd0, busy}, 9'd1);
        rst = 1'b1;
        step();
        chk("mr_oen", pad_oen, 9'h1FF);
        chk("mr_ie", pad_ie, 9'h000);
        chk("mr_pe", pad_pe, 9'h000);
        chk("mr_i", pad_i, 9'h000);
        chk("mr_cur", mux_cur, 9'h000);
        chk("mr_busy", {8'd0, busy}, 9'd0);
        chk("mr_gin", gpio_in, 9'h000);
        chk("mr_ain", alt_in, 9'h1FF);
        rst = 1'b0;

        // Randomised traffic against the model
        for (int i = 0; i < 600; i++) begin
            gpio_out = 9'($urandom); gpio_dir = 9'($urandom);
            gpio_pe  = 9'($urandom); alt_out  = 9'($urandom);
            alt_oe   = 9'($urandom); pad_c    = 9'($urandom);
            if ($urandom_range(0, 3) == 0) mux_req = 9'($urandom);
            rst = ($urandom_range(0, 63) == 0);
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
